frequency_meter: RTL and testbench

- Measures the frequency of a slow, asynchronous 1-bit input, such as the divided clock from the frequency divisor or a floor/door sensor pulse train.
- Counts rising edges of the input over a fixed gate window of clk50 cycles.
- Reports the count once per window, with a one-cycle valid strobe.
- Serves as the receive-side counterpart of the divisor: it recovers a frequency figure from a slow signal instead of generating the slow signal.

---
 rtl/frequency_meter_pkg.sv | 26 ++
 rtl/frequency_meter_edge_sync.sv | 30 +++
 rtl/frequency_meter.sv | 108 ++++++++++
 tb/tb_frequency_meter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frequency_meter_pkg.sv
// Shared types and constants for the frequency meter: FSM encoding, default
// window geometry and a constant-evaluable ceiling-log2 helper.
package frequency_meter_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int DEFAULT_GATE_CYCLES = 1000;
    localparam int DEFAULT_COUNT_WIDTH = 16;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/frequency_meter_edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge
// detector that emits one clk50-cycle pulse per rising edge.
module frequency_meter_edge_sync (
    input  logic clk50,
    input  logic reset_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // NOTE: non-blocking assignments make each flop sample the previous stage's
    // old value, forming a true shift chain; blocking would collapse it into one flop.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~prev;

endmodule

// File: rtl/frequency_meter.sv
// Counts rising edges of a slow asynchronous input over back-to-back gate
// windows of GATE_CYCLES clk50 cycles and reports each window's total.
module frequency_meter
    import frequency_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk50,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   signal_in,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   valid,
    output logic                   overflow,
    output logic                   busy
);

    localparam int                     GATE_WIDTH = clog2(GATE_CYCLES);
    localparam logic [GATE_WIDTH-1:0]  GATE_LAST  = GATE_WIDTH'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    state_t                 state;
    state_t                 state_next;
    logic [GATE_WIDTH-1:0]  gate_cnt;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic                   sat;
    logic                   edge_pulse;
    logic                   window_end;
    logic                   at_max;
    logic [COUNT_WIDTH-1:0] final_cnt;
    logic                   final_sat;

    frequency_meter_edge_sync u_edge_sync (
        .clk50      (clk50),
        .reset_n    (reset_n),
        .async_in   (signal_in),
        .edge_pulse (edge_pulse)
    );

    assign window_end = (state == MEASURE) && (gate_cnt == GATE_LAST);
    assign at_max     = (edge_cnt == COUNT_MAX);

    // The edge seen in the last gate cycle still belongs to this window.
    assign final_cnt = (edge_pulse && !at_max) ? edge_cnt + COUNT_WIDTH'(1) : edge_cnt;
    assign final_sat = sat | (edge_pulse & at_max);

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = MEASURE;
            MEASURE: if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MEASURE);
    end

    // Counters run only inside a window; idle, abort and window end all clear
    // them, which makes the next window start with no gap cycle.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if ((state == MEASURE) && enable && !window_end) begin
            gate_cnt <= gate_cnt + GATE_WIDTH'(1);
            if (edge_pulse) begin
                if (at_max) begin
                    sat <= 1'b1;
                end else begin
                    edge_cnt <= edge_cnt + COUNT_WIDTH'(1);
                end
            end
        end else begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= window_end;
            if (window_end) begin
                count    <= final_cnt;
                overflow <= final_sat;
            end
        end
    end

endmodule

// File: tb/tb_frequency_meter.sv
// Three meters share one stimulus (100-cycle/16-bit, 100-cycle/3-bit, 20-cycle/16-bit
// windows); a timestamp model of detected edges predicts every output each cycle.
module tb_frequency_meter;

    localparam int     NDUT  = 3;
    localparam longint NEVER = 64'd1000000000;

    logic clk50 = 1'b0;
    logic reset_n;
    logic enable;
    logic signal_in;

    logic [15:0]     cnt_a;
    logic [2:0]      cnt_b;
    logic [15:0]     cnt_c;
    logic [NDUT-1:0] valid_v;
    logic [NDUT-1:0] ovf_v;
    logic [NDUT-1:0] busy_v;

    frequency_meter #(.GATE_CYCLES(100), .COUNT_WIDTH(16)) dut_a (
        .clk50(clk50), .reset_n(reset_n), .enable(enable), .signal_in(signal_in),
        .count(cnt_a), .valid(valid_v[0]), .overflow(ovf_v[0]), .busy(busy_v[0])
    );

    frequency_meter #(.GATE_CYCLES(100), .COUNT_WIDTH(3)) dut_b (
        .clk50(clk50), .reset_n(reset_n), .enable(enable), .signal_in(signal_in),
        .count(cnt_b), .valid(valid_v[1]), .overflow(ovf_v[1]), .busy(busy_v[1])
    );

    frequency_meter #(.GATE_CYCLES(20), .COUNT_WIDTH(16)) dut_c (
        .clk50(clk50), .reset_n(reset_n), .enable(enable), .signal_in(signal_in),
        .count(cnt_c), .valid(valid_v[2]), .overflow(ovf_v[2]), .busy(busy_v[2])
    );

    always #5 clk50 = ~clk50;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle index of every posedge, and the posedge at which
    // each sampled rise reaches the counters (two synchronizer stages later).
    longint cyc = 0;
    bit     s_prev = 1'b0;
    longint rise_q[$];

    always @(posedge clk50) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            s_prev = 1'b0;
            rise_q.delete();
        end else begin
            if (signal_in && !s_prev) rise_q.push_back(cyc + 2);
            s_prev = signal_in;
        end
    end

    longint      en_e = NEVER;   // first posedge in MEASURE
    longint      en_a = NEVER;   // posedge that samples enable = 0
    logic [15:0] exp_cnt [NDUT];
    bit          exp_ovf [NDUT];

    int mode = 0;                // 0 hold, 1 periodic, 2 random
    int half = 5;
    int ph   = 0;

    function automatic longint gate_of(input int d);
        return (d == 2) ? 64'd20 : 64'd100;
    endfunction

    function automatic longint max_of(input int d);
        return (d == 1) ? 64'd7 : 64'd65535;
    endfunction

    function automatic logic [15:0] obs_cnt(input int d);
        case (d)
            0:       return cnt_a;
            1:       return {13'd0, cnt_b};
            default: return cnt_c;
        endcase
    endfunction

    function automatic longint rises_in(input longint lo, input longint hi);
        longint n;
        n = 0;
        foreach (rise_q[i]) if (rise_q[i] > lo && rise_q[i] <= hi) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d at cycle %0d: observed %0d, expected %0d", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        longint t, g, n;
        bit     busy_e, end_e;
        t = cyc;
        for (int d = 0; d < NDUT; d++) begin
            g      = gate_of(d);
            busy_e = (t >= en_e) && (t < en_a);
            end_e  = (en_e != NEVER) && (t >= en_e + g) && ((t - en_e) % g == 0) && (t <= en_a);
            if (end_e) begin
                n          = rises_in(t - g, t);
                exp_cnt[d] = 16'((n > max_of(d)) ? max_of(d) : n);
                exp_ovf[d] = (n > max_of(d));
            end
            chk("valid", d, 32'(valid_v[d]), 32'(end_e));
            chk("busy", d, 32'(busy_v[d]), 32'(busy_e));
            chk("count", d, 32'(obs_cnt(d)), 32'(exp_cnt[d]));
            chk("overflow", d, 32'(ovf_v[d]), 32'(exp_ovf[d]));
        end
    endtask

    task automatic drive_signal();
        case (mode)
            1: begin
                ph = ph + 1;
                if (ph >= half) begin
                    ph = 0;
                    signal_in = ~signal_in;
                end
            end
            2: if ($urandom_range(0, 7) == 0) signal_in = ~signal_in;
            default: ;
        endcase
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk50);
            check_all();
            drive_signal();
        end
    endtask

    task automatic set_enable(input bit v);
        if (v && !enable) begin
            en_e = cyc + 1;
            en_a = NEVER;
        end else if (!v && enable) begin
            en_a = cyc + 1;
        end
        enable = v;
    endtask

    task automatic wait_valid(input int d, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            seen = valid_v[d];
        end
        chk("valid_timeout", d, 32'(seen), 32'd1);
    endtask

    task automatic clear_model();
        en_e = NEVER;
        en_a = NEVER;
        for (int d = 0; d < NDUT; d++) begin
            exp_cnt[d] = 16'd0;
            exp_ovf[d] = 1'b0;
        end
    endtask

    longint mark;

    initial begin
        reset_n   = 1'b1;
        enable    = 1'b0;
        signal_in = 1'b0;
        clear_model();
        #1 reset_n = 1'b0;

        // Power-up reset state.
        step(3);
        reset_n = 1'b1;
        step(2);

        // Nominal: period-10 input running before the first window.
        mode = 1;
        half = 5;
        step(30);
        set_enable(1'b1);
        wait_valid(0, 120);
        chk("nominal_count", 0, 32'(cnt_a), 32'd10);
        chk("nominal_overflow", 0, 32'(ovf_v[0]), 32'd0);
        wait_valid(0, 120);
        chk("nominal_count2", 0, 32'(cnt_a), 32'd10);
        chk("nominal_busy", 0, 32'(busy_v[0]), 32'd1);

        // Saturation of the 3-bit meter, then recovery with a slow input.
        half = 2;
        wait_valid(1, 120);
        wait_valid(1, 120);
        chk("sat_count", 1, 32'(cnt_b), 32'd7);
        chk("sat_overflow", 1, 32'(ovf_v[1]), 32'd1);
        half = 20;
        wait_valid(1, 120);
        wait_valid(1, 120);
        wait_valid(1, 120);
        chk("slow_count_2_or_3", 1, 32'((cnt_b == 3'd2) || (cnt_b == 3'd3)), 32'd1);
        chk("slow_overflow", 1, 32'(ovf_v[1]), 32'd0);

        // Boundary edge on the 20-cycle meter, then constant 0 and 1 inputs.
        mode      = 0;
        signal_in = 1'b0;
        wait_valid(2, 30);
        wait_valid(2, 30);
        wait_valid(2, 30);
        chk("const0_count", 2, 32'(cnt_c), 32'd0);
        mark = cyc;
        step(17);
        signal_in = 1'b1;
        wait_valid(2, 30);
        chk("boundary_time", 2, 32'(cyc - mark), 32'd20);
        chk("boundary_count", 2, 32'(cnt_c), 32'd1);
        wait_valid(2, 30);
        chk("after_boundary_count", 2, 32'(cnt_c), 32'd0);
        wait_valid(2, 30);
        chk("const1_count", 2, 32'(cnt_c), 32'd0);

        // Abort 50 cycles into a window, then a fresh full window.
        mode = 1;
        half = 5;
        wait_valid(0, 120);
        wait_valid(0, 120);
        chk("pre_abort_count", 0, 32'(cnt_a), 32'd10);
        step(49);
        set_enable(1'b0);
        step(1);
        chk("abort_busy", 0, 32'(busy_v[0]), 32'd0);
        step(40);
        chk("abort_count_held", 0, 32'(cnt_a), 32'd10);
        set_enable(1'b1);
        mark = cyc + 1;
        wait_valid(0, 150);
        chk("refill_latency", 0, 32'(cyc - mark), 32'd100);

        // Asynchronous reset between clock edges 60 cycles into a window.
        wait_valid(0, 120);
        step(60);
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("reset_count", d, 32'(obs_cnt(d)), 32'd0);
            chk("reset_valid", d, 32'(valid_v[d]), 32'd0);
            chk("reset_overflow", d, 32'(ovf_v[d]), 32'd0);
            chk("reset_busy", d, 32'(busy_v[d]), 32'd0);
        end
        clear_model();
        step(3);
        reset_n = 1'b1;
        en_e    = cyc + 1;
        en_a    = NEVER;
        mark    = cyc;
        wait_valid(0, 200);
        chk("post_reset_latency", 0, 32'(cyc - mark), 32'd101);

        // Random input with occasional enable drops.
        mode = 2;
        for (int i = 0; i < 1500; i++) begin
            step(1);
            if ($urandom_range(0, 199) == 0) set_enable(~enable);
        end
        set_enable(1'b1);
        step(250);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
